// File: rtl/result_bcd_pkg.sv
// ---------------------------------------------------------------------------
// result_bcd_pkg
// Shared definitions for the signed-difference to BCD converter:
//   WIDTH       default width of the two's-complement difference D
//   DIGITS      default number of BCD magnitude digits
//   state_t     converter FSM states
//   bcd_digit_t one packed BCD digit
// ---------------------------------------------------------------------------
package result_bcd_pkg;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
// Ports:
//   din   in   4  scratch digit before the shift
//   dout  out  4  corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
   import result_bcd_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   // Inputs 5..9 map to 8..12; larger values never occur in a valid scratch.
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/result_bcd_converter.sv
// ---------------------------------------------------------------------------
// result_bcd_converter
// Converts a signed two's-complement difference into a sign flag plus BCD
// magnitude digits using a sequential double-dabble (one bit per clock).
// Latency is WIDTH+1 edges from the accepting edge to the done pulse.
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      convert the current D (ignored while busy)
//   D         in   WIDTH  signed difference, sampled on the accepting edge
//   busy      out  1      conversion in progress
//   done      out  1      one-cycle pulse: new results valid
//   neg       out  1      sign of last converted D
//   hundreds  out  4      BCD magnitude digit 2
//   tens      out  4      BCD magnitude digit 1
//   units     out  4      BCD magnitude digit 0
// DIGITS must be at least 3 since the three output digits are fixed ports.
// ---------------------------------------------------------------------------
module result_bcd_converter #(
   parameter int WIDTH  = result_bcd_pkg::WIDTH,
   parameter int DIGITS = result_bcd_pkg::DIGITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] D,
   output logic             busy,
   output logic             done,
   output logic             neg,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       units
);

   import result_bcd_pkg::*;

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int CAT_W = DIGITS * 4 + WIDTH;

   state_t                        state_q, state_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          neg_q, neg_d;
   logic                          neg_cap_q, neg_cap_d;
   logic [WIDTH-1:0]              mag_q, mag_d;
   bcd_digit_t [DIGITS-1:0]       scratch_q, scratch_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   bcd_digit_t                    hundreds_q, hundreds_d;
   bcd_digit_t                    tens_q, tens_d;
   bcd_digit_t                    units_q, units_d;

   bcd_digit_t [DIGITS-1:0]       adj;
   logic [WIDTH-1:0]              mag_in;
   logic [CAT_W-1:0]              cat;

   // Per-digit add-3 correction applied ahead of every shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (scratch_q[g]),
         .dout (adj[g])
      );
   end

   // Unsigned WIDTH-bit magnitude; -2^(WIDTH-1) negates to itself, which read
   // unsigned is exactly 2^(WIDTH-1).
   assign mag_in = D[WIDTH-1] ? -D : D;
   assign cat    = {adj, mag_q};

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      neg_d      = neg_q;
      neg_cap_d  = neg_cap_q;
      mag_d      = mag_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      hundreds_d = hundreds_q;
      tens_d     = tens_q;
      units_d    = units_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // Sign comes from the MSB, so D=0 can never report negative.
               neg_cap_d = D[WIDTH-1];
               mag_d     = mag_in;
               scratch_d = '0;
               cnt_d     = '0;
               state_d   = SHIFT;
               busy_d    = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               state_d    = DONE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               neg_d      = neg_cap_q;
               hundreds_d = scratch_q[2];
               tens_d     = scratch_q[1];
               units_d    = scratch_q[0];
            end else begin
               {scratch_d, mag_d} = cat << 1;
               cnt_d              = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         neg_q      <= 1'b0;
         neg_cap_q  <= 1'b0;
         mag_q      <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         hundreds_q <= '0;
         tens_q     <= '0;
         units_q    <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         neg_q      <= neg_d;
         neg_cap_q  <= neg_cap_d;
         mag_q      <= mag_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         hundreds_q <= hundreds_d;
         tens_q     <= tens_d;
         units_q    <= units_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign neg      = neg_q;
   assign hundreds = hundreds_q;
   assign tens     = tens_q;
   assign units    = units_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_result_bcd_converter
// Directed vectors with hand-computed sign/BCD results, edge-exact latency,
// busy/done handshake, start-while-busy, mid-conversion reset, back-to-back.
// ---------------------------------------------------------------------------
module tb_result_bcd_converter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] D;
   logic       busy, done, neg;
   logic [3:0] hundreds, tens, units;

   int n_pass    = 0;
   int n_total   = 0;
   int n_overlap = 0;

   always #5 clk = ~clk;

   result_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .D        (D),
      .busy     (busy),
      .done     (done),
      .neg      (neg),
      .hundreds (hundreds),
      .tens     (tens),
      .units    (units)
   );

   always @(negedge clk) if (busy && done) n_overlap++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic [12:0] res();
      return {neg, hundreds, tens, units};
   endfunction

   // One conversion from the accepting edge E0 to one edge past E9.
   // inj>0 raises start with D=8'h55 so that it is sampled at edge E<inj>.
   task automatic conv(input string tag, input logic [7:0] d,
                       input logic [12:0] exp, input int inj);
      @(negedge clk); start = 1'b1; D = d;
      @(posedge clk); #1;
      chk({tag, "_e0"}, {busy, done}, 2'b10);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == inj) begin start = 1'b1; D = 8'h55; end
         else begin start = 1'b0; D = 8'($urandom); end
         @(posedge clk); #1;
         chk($sformatf("%s_e%0d", tag, k), {busy, done}, 2'b10);
      end
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_e9_done"}, {busy, done}, 2'b01);
      chk({tag, "_result"}, res(), exp);
      @(posedge clk); #1;
      chk({tag, "_e10_idle"}, {busy, done}, 2'b00);
      chk({tag, "_hold"}, res(), exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      rst_n = 1'b0; start = 1'b0; D = 8'h00;
      #12;
      chk("reset_state", {busy, done, res()}, 15'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", {busy, done}, 2'b00);

      conv("d03", 8'h03, {1'b0, 12'h003}, 0);
      conv("dFD", 8'hFD, {1'b1, 12'h003}, 0);
      conv("d00", 8'h00, {1'b0, 12'h000}, 0);
      conv("d80", 8'h80, {1'b1, 12'h128}, 0);
      conv("d7F", 8'h7F, {1'b0, 12'h127}, 0);
      conv("ign", 8'h0A, {1'b0, 12'h010}, 4);

      // Reset in the middle of a conversion, just before E5.
      @(negedge clk); start = 1'b1; D = 8'h3C;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("async_clear", {busy, done, res()}, 15'h0);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("no_done_after_abort", seen, 0);
      conv("dF1", 8'hF1, {1'b1, 12'h015}, 0);

      // Back-to-back: start held through DONE.
      @(negedge clk); start = 1'b1; D = 8'h0C;
      @(posedge clk); #1; D = 8'hF4;
      repeat (8) @(posedge clk);
      #1; chk("b2b_1_busy_e8", {busy, done}, 2'b10);
      @(posedge clk); #1;
      chk("b2b_1_done", {busy, done}, 2'b01);
      chk("b2b_1_result", res(), {1'b0, 12'h012});
      @(posedge clk); #1;
      chk("b2b_2_accept", {busy, done}, 2'b10);
      @(negedge clk); start = 1'b0;
      repeat (8) @(posedge clk);
      #1; chk("b2b_2_busy_e8", {busy, done}, 2'b10);
      @(posedge clk); #1;
      chk("b2b_2_done", {busy, done}, 2'b01);
      chk("b2b_2_result", res(), {1'b1, 12'h012});
      @(posedge clk); #1;
      chk("b2b_idle", {busy, done}, 2'b00);

      chk("busy_done_exclusive", n_overlap, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
